ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB RV32 datapath. It replaces hand-driven control stimulus with a clocked state machine. The sequencer captures the fetched instruction and steps it through FETCH, DECODE, EXEC, MEM and WB. In each state it drives the datapath strobes, the ALU op and the PC update select, and it counts retired instructions.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/alu_op_dec.sv | 29 ++
 rtl/ctrl_seq.sv | 156 +++++++++++++++
 tb/tb_ctrl_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32 multi-cycle control sequencer: opcodes,
// ALU op codes, PC source selects and the sequencer state enum.
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_P4  = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  function automatic logic opc_legal(input logic [6:0] opc);
    return (opc == OPC_R)     || (opc == OPC_I)      || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JAL);
  endfunction

endpackage

// File: rtl/alu_op_dec.sv
// Combinational ALU op decoder from the captured instruction fields.
module alu_op_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opc_i,
  input  logic [2:0] f3_i,
  input  logic       f7b5_i,
  output logic [2:0] op_o
);

  always_comb begin
    op_o = ALU_ADD;
    case (opc_i)
      OPC_R, OPC_I: begin
        case (f3_i)
          // funct7[5] selects sub only for register-register ops
          3'b000:  op_o = ((opc_i == OPC_R) && f7b5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  op_o = ALU_AND;
          3'b110:  op_o = ALU_OR;
          3'b010:  op_o = ALU_SLT;
          default: op_o = ALU_ADD;
        endcase
      end
      OPC_BRANCH: op_o = ALU_SUB;
      default:    op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with retire
// counter, optional retire limit and sticky illegal-opcode halt.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned MAX_INSNS = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             Mem2Reg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [2:0]       op,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic             LIMIT_EN = (MAX_INSNS != 0);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_INSNS);

  state_e           state_q, state_d;
  logic [6:0]       ir_opc_q, ir_opc_d;
  logic [2:0]       ir_f3_q, ir_f3_d;
  logic             ir_f7b5_q, ir_f7b5_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             retire;
  logic [2:0]       dec_op;

  logic unused_ins;
  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

  alu_op_dec u_alu_op_dec (
    .opc_i  (ir_opc_q),
    .f3_i   (ir_f3_q),
    .f7b5_i (ir_f7b5_q),
    .op_o   (dec_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_opc_q  <= '0;
      ir_f3_q   <= '0;
      ir_f7b5_q <= 1'b0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_opc_q  <= ir_opc_d;
      ir_f3_q   <= ir_f3_d;
      ir_f7b5_q <= ir_f7b5_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_opc_d  = ir_opc_q;
    ir_f3_d   = ir_f3_q;
    ir_f7b5_d = ir_f7b5_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrc    = 1'b0;
    Mem2Reg   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    op        = ALU_ADD;
    PCWrite   = 1'b0;
    PCSrc     = PCSRC_P4;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        IRWrite   = 1'b1;
        ir_opc_d  = ins[6:0];
        ir_f3_d   = ins[14:12];
        ir_f7b5_d = ins[30];
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (opc_legal(ir_opc_q)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        ALUSrc = !((ir_opc_q == OPC_R) || (ir_opc_q == OPC_BRANCH));
        op     = dec_op;
        if (ir_opc_q == OPC_BRANCH) begin
          // Branch resolves here on the live zero flag; the only input-to-output path.
          PCWrite = 1'b1;
          PCSrc   = zero ? PCSRC_BR : PCSRC_P4;
          retire  = 1'b1;
        end else if ((ir_opc_q == OPC_LOAD) || (ir_opc_q == OPC_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ALUSrc = 1'b1;
        op     = ALU_ADD;
        if (ir_opc_q == OPC_LOAD) begin
          MemRead = 1'b1;
          state_d = S_WB;
        end else begin
          MemWrite = 1'b1;
          PCWrite  = 1'b1;
          retire   = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        Mem2Reg  = (ir_opc_q == OPC_LOAD);
        PCWrite  = 1'b1;
        PCSrc    = (ir_opc_q == OPC_JAL) ? PCSRC_JMP : PCSRC_P4;
        retire   = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
      state_d   = (LIMIT_EN && (retired_d == LIMIT)) ? S_HALT : S_FETCH;
    end
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: per-cycle expected outputs come from an
// instruction-class model queued by the stimulus, checked every negedge.
module tb_ctrl_seq;

  localparam int MAXI = 11;

  logic        clk, rst_n, start, zero;
  logic [31:0] ins;
  logic        IRWrite, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, PCWrite;
  logic [2:0]  op;
  logic [1:0]  PCSrc;
  logic        busy, halted, illegal;
  logic [15:0] retired;

  ctrl_seq #(.MAX_INSNS(MAXI), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .zero(zero),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg),
    .MemRead(MemRead), .MemWrite(MemWrite), .op(op), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .busy(busy), .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  typedef struct packed {
    logic irw, rw, alusrc, m2r, mr, mw;
    logic [2:0] op;
    logic pcw;
    logic [1:0] pcsrc;
    logic busy, halted, ill;
    logic [15:0] ret;
  } exp_t;

  exp_t act;
  assign act = {IRWrite, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op,
                PCWrite, PCSrc, busy, halted, illegal, retired};

  exp_t        expq[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] m_ret = 0;
  logic        m_ill = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      nvec++;
      if (act !== e) begin
        nerr++;
        $display("FAIL cycle t=%0t got=%h want=%h", $time, act, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] w);
    nvec++;
    if (a !== w) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", name, a, w);
    end
  endtask

  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.op = 3'b010;
    e.ret = m_ret;
    e.ill = m_ill;
    return e;
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] i);
    logic [6:0] opc;
    opc = i[6:0];
    if (opc == 7'h63) return 3'b110;
    if (opc != 7'h33 && opc != 7'h13) return 3'b010;
    case (i[14:12])
      3'b000:  return (opc == 7'h33 && i[30]) ? 3'b110 : 3'b010;
      3'b111:  return 3'b000;
      3'b110:  return 3'b001;
      3'b010:  return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Called in the FETCH cycle; returns in the cycle after the instruction.
  task automatic exec_insn(input logic [31:0] i, input logic z, input bit abort_in_mem);
    exp_t e;
    int n;
    logic [6:0] opc;
    logic is_ld, is_st, is_br, legal;
    opc = i[6:0];
    is_ld = (opc == 7'h03); is_st = (opc == 7'h23); is_br = (opc == 7'h63);
    legal = (opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F});
    ins = i; zero = z; n = 0;
    e = base(); e.irw = 1; e.busy = 1; expq.push_back(e); n++;
    e = base(); e.busy = 1; expq.push_back(e); n++;
    if (!legal) begin
      m_ill = 1;
      repeat (n) @(posedge clk);
      #1;
      return;
    end
    e = base(); e.busy = 1;
    e.alusrc = !(opc == 7'h33 || is_br);
    e.op = alu_of(i);
    if (is_br) begin e.pcw = 1; e.pcsrc = z ? 2'b01 : 2'b00; end
    expq.push_back(e); n++;
    if (abort_in_mem) begin
      repeat (n) @(posedge clk);
      #1;
      return;
    end
    if (is_ld || is_st) begin
      e = base(); e.busy = 1; e.alusrc = 1;
      if (is_ld) e.mr = 1;
      else begin e.mw = 1; e.pcw = 1; end
      expq.push_back(e); n++;
    end
    if (!is_br && !is_st) begin
      e = base(); e.busy = 1; e.rw = 1; e.m2r = is_ld; e.pcw = 1;
      e.pcsrc = (opc == 7'h6F) ? 2'b10 : 2'b00;
      expq.push_back(e); n++;
    end
    repeat (n) @(posedge clk);
    #1;
    m_ret = m_ret + 16'd1;
  endtask

  task automatic push_halt(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e = base(); e.halted = 1;
      expq.push_back(e);
    end
    start = 1;
    repeat (n) @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic start_run();
    exp_t e;
    e = base();
    expq.push_back(e);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic do_reset(input string name);
    rst_n = 0;
    #1;
    chk(name, {1'b0, act}, 32'h0080_0000);
    m_ret = 0; m_ill = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] prog[11];
    logic        zs[11];
    prog = '{32'h002081B3, 32'h402081B3, 32'h0000A283, 32'h0050A223,
             32'h00208463, 32'h00208463, 32'h008000EF, 32'h4000E093,
             32'h0020A1B3, 32'h0020F1B3, 32'h40108093};
    zs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    start = 0; ins = 0; zero = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    chk("reset_state", {1'b0, act}, 32'h0080_0000);
    @(posedge clk);
    #1 rst_n = 1;

    start_run();
    for (int k = 0; k < 11; k++) begin
      exec_insn(prog[k], zs[k], 1'b0);
      if (k == 0) chk("add_retired", 32'(retired), 32'd1);
    end
    push_halt(3);
    chk("limit_halted", 32'(halted), 32'd1);
    chk("limit_retired", 32'(retired), 32'd11);

    do_reset("reset_after_halt");
    start_run();
    exec_insn(32'h0000A283, 1'b0, 1'b1);
    chk("lw_mem_memread", 32'(MemRead), 32'd1);
    do_reset("reset_mid_mem");
    begin
      exp_t e;
      e = base(); expq.push_back(e); expq.push_back(e);
      repeat (2) @(posedge clk);
      #1;
    end

    start_run();
    exec_insn(32'h0000007F, 1'b0, 1'b0);
    push_halt(3);
    chk("illegal_flag", 32'(illegal), 32'd1);
    chk("illegal_retired", 32'(retired), 32'd0);

    for (int k = 0; k < 5 && expq.size() > 0; k++) @(posedge clk);
    #6;
    if (expq.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain left=%0d want=0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
